cp0_regfile: RTL and testbench

Parametrised MIPS coprocessor-0 register file for the pipelined core, sitting beside the MEM/WB stage and serving MFC0/MTC0, exception commit and ERET. It extends the earlier fixed CP0 block in several ways: a configurable Count prescaler, a configurable number of hardware interrupt lines, and a generic exception-code interface with BadVAddr capture. It also adds EXL-aware EPC protection, a timer-interrupt bit in Cause and a combinational interrupt-request output for the pipeline.

---
 rtl/cp0_pkg.sv | 47 ++++
 rtl/cp0_timer.sv | 63 ++++++
 rtl/cp0_regfile.sv | 140 ++++++++++++++
 tb/tb_cp0_regfile.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_pkg
// Brief    : Shared CP0 register numbers, field positions and ExcCodes.
// Revision : 1.0 - initial release
// ============================================================================
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam int ST_CU0    = 28;
  localparam int ST_IM_LO  = 8;
  localparam int ST_EXL    = 1;
  localparam int ST_IE     = 0;
  localparam int CA_BD     = 31;
  localparam int CA_TI     = 30;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  // CU0, IM[7:0], EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;

  // A faulting delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer
// Brief    : Prescaled Count, Compare and the sticky timer-interrupt flag.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_count_i,
  input  logic        we_compare_i,
  input  logic [31:0] wdata_i,
  input  logic        suppress_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [3:0]  r_presc;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  logic w_wr_count;
  logic w_wr_compare;
  logic w_wrap;

  assign w_wr_count   = we_count_i & ~suppress_i;
  assign w_wr_compare = we_compare_i & ~suppress_i;
  assign w_wrap       = (r_presc == 4'(COUNT_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= wdata_i;
        r_presc <= '0;
      end else begin
        r_presc <= w_wrap ? 4'd0 : (r_presc + 4'd1);
        if (w_wrap) r_count <= r_count + 32'd1;
      end
      // A Compare write acknowledges the interrupt even on a matching cycle.
      if (w_wr_compare) begin
        r_compare <= wdata_i;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign count_o   = r_count;
  assign compare_o = r_compare;
  assign ti_o      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cp0_regfile
// Brief    : MIPS CP0 register file: MFC0/MTC0, exception commit, ERET, IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          COUNT_DIV  = 2,
  parameter int          N_HW_INT   = 6,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic [4:0]          raddr_i,
  output logic [31:0]         rdata_o,
  input  logic [N_HW_INT-1:0] hw_int_i,
  input  logic                exc_valid_i,
  input  logic [4:0]          exc_code_i,
  input  logic [31:0]         exc_pc_i,
  input  logic                exc_bd_i,
  input  logic [31:0]         exc_badvaddr_i,
  input  logic                eret_i,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic                timer_int_o,
  output logic                int_req_o,
  output logic [31:0]         exc_vector_o
);

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_bd;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_ip_hw;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [5:0]  w_hw6;
  logic [7:0]  w_ip;
  logic [31:0] w_cause;
  logic [31:0] w_status_nxt;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .we_count_i   (we_i && (waddr_i == REG_COUNT)),
    .we_compare_i (we_i && (waddr_i == REG_COMPARE)),
    .wdata_i      (wdata_i),
    .suppress_i   (exc_valid_i),
    .count_o      (w_count),
    .compare_o    (w_compare),
    .ti_o         (w_ti)
  );

  always_comb begin
    w_hw6                 = '0;
    w_hw6[N_HW_INT-1:0]   = hw_int_i;
  end

  // ERET applies after an MTC0 to Status in the same cycle.
  always_comb begin
    w_status_nxt = r_status;
    if (we_i && (waddr_i == REG_STATUS)) w_status_nxt = wdata_i & STATUS_WMASK;
    if (eret_i) w_status_nxt[ST_EXL] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= STATUS_RESET;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
    end else begin
      r_ip_hw <= w_hw6;
      if (exc_valid_i) begin
        r_status[ST_EXL] <= 1'b1;
        r_exccode        <= exc_code_i;
        if (!r_status[ST_EXL]) begin
          r_epc <= epc_of(exc_pc_i, exc_bd_i);
          r_bd  <= exc_bd_i;
        end
        if ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES))
          r_badvaddr <= exc_badvaddr_i;
      end else begin
        r_status <= w_status_nxt;
        if (we_i && (waddr_i == REG_CAUSE)) r_ip_sw <= wdata_i[1:0];
        if (we_i && (waddr_i == REG_EPC))   r_epc   <= wdata_i;
      end
    end
  end

  assign w_ip = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};

  always_comb begin
    w_cause                          = '0;
    w_cause[CA_BD]                   = r_bd;
    w_cause[CA_TI]                   = w_ti;
    w_cause[CA_IP_LO+7:CA_IP_LO]     = w_ip;
    w_cause[CA_EXC_LO+4:CA_EXC_LO]   = r_exccode;
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = r_badvaddr;
      REG_COUNT:    rdata_o = w_count;
      REG_COMPARE:  rdata_o = w_compare;
      REG_STATUS:   rdata_o = r_status;
      REG_CAUSE:    rdata_o = w_cause;
      REG_EPC:      rdata_o = r_epc;
      REG_PRID:     rdata_o = PRID_VAL;
      REG_CONFIG:   rdata_o = CONFIG_VAL;
      default:      rdata_o = '0;
    endcase
  end

  assign int_req_o    = r_status[ST_IE] & ~r_status[ST_EXL] &
                        (|(w_ip & r_status[ST_IM_LO+7:ST_IM_LO]));
  assign status_o     = r_status;
  assign cause_o      = w_cause;
  assign epc_o        = r_epc;
  assign timer_int_o  = w_ti;
  assign exc_vector_o = EXC_VECTOR;

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_regfile
// Brief    : Directed self-checking bench for cp0_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  hw_int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;
  logic        int_req_o;
  logic [31:0] exc_vector_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .hw_int_i       (hw_int_i),
    .exc_valid_i    (exc_valid_i),
    .exc_code_i     (exc_code_i),
    .exc_pc_i       (exc_pc_i),
    .exc_bd_i       (exc_bd_i),
    .exc_badvaddr_i (exc_badvaddr_i),
    .eret_i         (eret_i),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .timer_int_o    (timer_int_o),
    .int_req_o      (int_req_o),
    .exc_vector_o   (exc_vector_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    raddr_i = a;
    #1;
    d = rdata_o;
  endtask

  task automatic idle();
    we_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; raddr_i = '0; hw_int_i = '0; waddr_i = '0; wdata_i = '0;
    exc_code_i = '0; exc_pc_i = '0; exc_bd_i = 1'b0; exc_badvaddr_i = '0;
    idle();
    step(); step();
    chk("rst_status", status_o, 32'h1000_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_ti", {31'b0, timer_int_o}, 32'h0);
    chk("rst_irq", {31'b0, int_req_o}, 32'h0);
    rd(5'd9, v); chk("rst_count", v, 32'h0);

    // Timer: Compare=5 written on the first cycle out of reset
    rst = 1'b0; we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd5;
    step(); idle();
    chk("ti_clear_wins", {31'b0, timer_int_o}, 32'h0);
    for (int i = 0; i < 9; i++) step();
    rd(5'd9, v); chk("count_at_10", v, 32'd5);
    chk("ti_before", {31'b0, timer_int_o}, 32'h0);
    step();
    chk("ti_at_11", {31'b0, timer_int_o}, 32'h1);
    chk("cause_ti", cause_o, 32'h4000_8000);
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'hFFFF_FFFF;
    step(); idle();
    chk("ti_ack", {31'b0, timer_int_o}, 32'h0);

    // Delay-slot exception, EXL=0
    exc_valid_i = 1'b1; exc_code_i = 5'd8; exc_pc_i = 32'h8000_0104; exc_bd_i = 1'b1;
    step(); idle();
    chk("exc_epc", epc_o, 32'h8000_0100);
    chk("exc_cause", cause_o, 32'h8000_0020);
    chk("exc_status", status_o, 32'h1000_0002);

    // Nested AdEL with EXL=1
    exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h8000_0200; exc_bd_i = 1'b0;
    exc_badvaddr_i = 32'h0000_0003;
    step(); idle();
    chk("nest_epc", epc_o, 32'h8000_0100);
    rd(5'd8, v); chk("nest_badvaddr", v, 32'h3);
    chk("nest_cause", cause_o, 32'h8000_0010);

    // Interrupt path: IM2+IE with EXL still set, then ERET
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
    step(); idle();
    chk("st_mask", status_o, 32'h1000_FF03);
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0403;
    step(); idle();
    hw_int_i = 6'b000001;
    #1;
    chk("irq_lat0", {31'b0, int_req_o}, 32'h0);
    step();
    chk("ip2_cause", cause_o, 32'h8000_0410);
    chk("irq_exl_mask", {31'b0, int_req_o}, 32'h0);
    eret_i = 1'b1;
    step(); idle();
    chk("eret_status", status_o, 32'h1000_0401);
    chk("irq_on", {31'b0, int_req_o}, 32'h1);

    // Exception drops same-cycle MTC0 Status
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0;
    exc_valid_i = 1'b1; exc_code_i = 5'd0; exc_pc_i = 32'h8000_0300; exc_bd_i = 1'b0;
    step(); idle();
    chk("pri_status", status_o, 32'h1000_0403);
    chk("pri_epc", epc_o, 32'h8000_0300);
    chk("pri_irq", {31'b0, int_req_o}, 32'h0);

    // Exception beats ERET
    exc_valid_i = 1'b1; eret_i = 1'b1; exc_code_i = 5'd9; exc_pc_i = 32'h8000_0400;
    step(); idle();
    chk("exc_eret_status", status_o, 32'h1000_0403);
    chk("exc_eret_cause", cause_o, 32'h0000_0424);
    chk("exc_eret_epc", epc_o, 32'h8000_0300);

    // MTC0 Status with ERET: written value then EXL cleared
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_FF03; eret_i = 1'b1;
    step(); idle();
    chk("mtc0_eret", status_o, 32'h1000_FF01);
    chk("irq_all_im", {31'b0, int_req_o}, 32'h1);

    // Count load clears the prescaler; wrap from all-ones
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h100;
    step(); idle();
    rd(5'd9, v); chk("count_load", v, 32'h100);
    step();
    rd(5'd9, v); chk("count_hold", v, 32'h100);
    step();
    rd(5'd9, v); chk("count_inc", v, 32'h101);
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hFFFF_FFFF;
    step(); idle(); step(); step();
    rd(5'd9, v); chk("count_wrap", v, 32'h0);

    // Read map
    rd(5'd15, v); chk("prid", v, 32'h004C_0102);
    rd(5'd16, v); chk("config", v, 32'h0000_8000);
    rd(5'd3, v);  chk("unmapped", v, 32'h0);
    chk("vector", exc_vector_o, 32'hBFC0_0380);

    // Mid-run reset overrides a live interrupt line
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_status", status_o, 32'h1000_0000);
    chk("mrst_cause", cause_o, 32'h0);
    chk("mrst_epc", epc_o, 32'h0);
    chk("mrst_ti", {31'b0, timer_int_o}, 32'h0);
    chk("mrst_irq", {31'b0, int_req_o}, 32'h0);
    rd(5'd8, v);  chk("mrst_badvaddr", v, 32'h0);
    rd(5'd9, v);  chk("mrst_count", v, 32'h0);
    rd(5'd11, v); chk("mrst_compare", v, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
